// File: rtl/johnson_decoder_if.sv
// Johnson decoder bus: sampled code in, decoded phase and monitor status out.
interface johnson_decoder_if #(
  parameter int N      = 4,
  parameter int WRAP_W = 8
);
  localparam int IW = $clog2(2 * N);

  logic [N-1:0]      jin;
  logic [IW-1:0]     phase;
  logic              valid;
  logic              locked;
  logic              dir;
  logic              err_code;
  logic              err_step;
  logic [WRAP_W-1:0] wraps;

  modport master (
    output jin,
    input  phase, valid, locked, dir, err_code, err_step, wraps
  );

  modport slave (
    input  jin,
    output phase, valid, locked, dir, err_code, err_step, wraps
  );
endinterface

// File: rtl/johnson_decoder.sv
// Johnson code decoder/monitor: decodes to a phase index, locks onto forward stepping,
// counts revolutions and flags faults. Define JDEC_DIR_EN to accept backward steps.
module johnson_decoder #(
  parameter int N        = 4,
  parameter int LOCK_CNT = 2,
  parameter int WRAP_W   = 8
) (
  input  logic              clk,
  input  logic              clear,
  johnson_decoder_if.slave  bus
);
  localparam int            IW   = $clog2(2 * N);
  localparam logic [IW-1:0] LAST = IW'(2 * N - 1);
  localparam logic [N-1:0]  ONES = '1;
`ifdef JDEC_DIR_EN
  localparam bit DIR_EN = 1'b1;
`else
  localparam bit DIR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {HUNT, LOCKED, FAULT} state_t;
  state_t state, state_nx;

  logic [N-1:0]      jin_q;
  logic              s1_vld;
  logic [IW-1:0]     phase_q, phase_nx;
  logic [IW-1:0]     prev_q, prev_nx;
  logic              prev_vld_q, prev_vld_nx;
  logic [3:0]        run_q, run_nx;
  logic              valid_q, valid_nx;
  logic              dir_q, dir_nx;
  logic              err_code_q, err_code_nx;
  logic              err_step_q, err_step_nx;
  logic [WRAP_W-1:0] wraps_q, wraps_nx;

  logic              legal;
  logic [IW-1:0]     idx;
  logic [N-1:0]      cand;
  logic [IW-1:0]     prev_inc, prev_dec;
  logic              is_hold, is_fwd, is_bwd;

  always_comb begin
    legal = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < 2 * N; i++) begin
      cand = (i <= N) ? ~(ONES >> i) : (ONES >> (i - N));
      if (jin_q == cand) begin
        legal = 1'b1;
        idx   = IW'(i);
      end
    end
  end

  assign prev_inc = (prev_q == LAST) ? '0 : prev_q + 1'b1;
  assign prev_dec = (prev_q == '0) ? LAST : prev_q - 1'b1;
  assign is_hold  = (idx == prev_q);
  assign is_fwd   = (idx == prev_inc);
  assign is_bwd   = DIR_EN && (idx == prev_dec);

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) state <= HUNT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    phase_nx    = phase_q;
    valid_nx    = valid_q;
    prev_nx     = prev_q;
    prev_vld_nx = prev_vld_q;
    run_nx      = run_q;
    dir_nx      = dir_q;
    err_code_nx = err_code_q;
    err_step_nx = err_step_q;
    wraps_nx    = wraps_q;

    if (s1_vld && legal) begin
      phase_nx = idx;
      valid_nx = 1'b1;
    end

    unique case (state)
      HUNT: begin
        if (s1_vld) begin
          if (!legal) begin
            run_nx = '0;
          end else if (!prev_vld_q) begin
            prev_nx     = idx;
            prev_vld_nx = 1'b1;
          end else if (is_hold) begin
            run_nx = run_q;
          end else if (is_fwd || is_bwd) begin
            run_nx  = run_q + 4'd1;
            prev_nx = idx;
            dir_nx  = !is_fwd;
            if (run_nx == 4'(LOCK_CNT)) state_nx = LOCKED;
          end else begin
            run_nx  = '0;
            prev_nx = idx;
          end
        end
      end
      LOCKED: begin
        if (s1_vld) begin
          if (!legal) begin
            err_code_nx = 1'b1;
            state_nx    = FAULT;
          end else if (is_hold) begin
            prev_nx = prev_q;
          end else if (is_fwd) begin
            prev_nx = idx;
            dir_nx  = 1'b0;
            if (prev_q == LAST) wraps_nx = wraps_q + 1'b1;
          end else if (is_bwd) begin
            prev_nx = idx;
            dir_nx  = 1'b1;
            if (prev_q == '0) wraps_nx = wraps_q - 1'b1;
          end else begin
            err_step_nx = 1'b1;
            state_nx    = FAULT;
          end
        end
      end
      FAULT: begin
        // the sample seen during FAULT is decoded for phase but never step-classified
        state_nx    = HUNT;
        run_nx      = '0;
        prev_vld_nx = 1'b0;
      end
      default: state_nx = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      jin_q      <= '0;
      s1_vld     <= 1'b0;
      phase_q    <= '0;
      valid_q    <= 1'b0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      run_q      <= '0;
      dir_q      <= 1'b0;
      err_code_q <= 1'b0;
      err_step_q <= 1'b0;
      wraps_q    <= '0;
    end else begin
      jin_q      <= bus.jin;
      s1_vld     <= 1'b1;
      phase_q    <= phase_nx;
      valid_q    <= valid_nx;
      prev_q     <= prev_nx;
      prev_vld_q <= prev_vld_nx;
      run_q      <= run_nx;
      dir_q      <= dir_nx;
      err_code_q <= err_code_nx;
      err_step_q <= err_step_nx;
      wraps_q    <= wraps_nx;
    end
  end

  assign bus.phase    = phase_q;
  assign bus.valid    = valid_q;
  assign bus.locked   = (state == LOCKED);
  assign bus.dir      = dir_q & DIR_EN;
  assign bus.err_code = err_code_q;
  assign bus.err_step = err_step_q;
  assign bus.wraps    = wraps_q;
endmodule

// File: tb/tb_johnson_decoder.sv
// Directed bench for johnson_decoder with a table-driven reference model compared every cycle.
module tb_johnson_decoder;
  localparam int N = 4, LOCK_CNT = 2, WRAP_W = 8, L = 2 * N;
`ifdef JDEC_DIR_EN
  localparam bit DIR = 1'b1;
`else
  localparam bit DIR = 1'b0;
`endif

  logic clk = 1'b0;
  logic clear = 1'b0;
  int checks = 0;
  int errors = 0;

  johnson_decoder_if #(.N(N), .WRAP_W(WRAP_W)) bus ();
  johnson_decoder #(.N(N), .LOCK_CNT(LOCK_CNT), .WRAP_W(WRAP_W)) dut (
    .clk(clk), .clear(clear), .bus(bus)
  );

  always #5 clk = ~clk;

  // Johnson sequence table generated by shifting in the inverted LSB at the MSB
  logic [N-1:0] jtab [L];
  int  e_phase, e_wraps, prev, run;
  bit  e_valid, e_locked, e_dir, e_ec, e_es, m_fault, have_prev, pend_v;
  logic [N-1:0] pend;

  function automatic int lookup(logic [N-1:0] c);
    for (int i = 0; i < L; i++) if (jtab[i] == c) return i;
    return -1;
  endfunction

  initial begin
    logic [N-1:0] c;
    int i_new, d;
    c = '0;
    for (int i = 0; i < L; i++) begin
      jtab[i] = c;
      c = {~c[0], c[N-1:1]};
    end
    forever begin
      @(posedge clk or negedge clear);
      if (!clear) begin
        e_phase = 0; e_wraps = 0; prev = 0; run = 0;
        e_valid = 0; e_locked = 0; e_dir = 0; e_ec = 0; e_es = 0;
        m_fault = 0; have_prev = 0; pend_v = 0;
      end else begin
        if (pend_v) begin
          i_new = lookup(pend);
          if (i_new >= 0) begin e_phase = i_new; e_valid = 1; end
          if (m_fault) begin
            m_fault = 0; run = 0; have_prev = 0;
          end else if (i_new < 0) begin
            if (e_locked) begin e_ec = 1; e_locked = 0; m_fault = 1; end
            else run = 0;
          end else if (!have_prev) begin
            prev = i_new; have_prev = 1;
          end else begin
            d = (i_new - prev + L) % L;
            if (d == 0) begin
            end else if (d == 1 || (DIR && d == L - 1)) begin
              e_dir = (d != 1);
              if (e_locked && d == 1 && prev == L - 1) e_wraps = (e_wraps + 1) % 256;
              if (e_locked && d != 1 && prev == 0) e_wraps = (e_wraps + 255) % 256;
              prev = i_new;
              if (!e_locked) begin
                run++;
                if (run == LOCK_CNT) e_locked = 1;
              end
            end else if (e_locked) begin
              e_es = 1; e_locked = 0; m_fault = 1;
            end else begin
              run = 0; prev = i_new;
            end
          end
        end
        pend = bus.jin;
        pend_v = 1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      checks++;
      if (bus.phase !== 3'(e_phase) || bus.valid !== e_valid || bus.locked !== e_locked ||
          bus.dir !== e_dir || bus.err_code !== e_ec || bus.err_step !== e_es ||
          bus.wraps !== 8'(e_wraps)) begin
        errors++;
        $display("FAIL model_cmp t=%0t got ph=%0d v=%0b l=%0b d=%0b ec=%0b es=%0b w=%0d want ph=%0d v=%0b l=%0b d=%0b ec=%0b es=%0b w=%0d",
                 $time, bus.phase, bus.valid, bus.locked, bus.dir, bus.err_code, bus.err_step,
                 bus.wraps, e_phase, e_valid, e_locked, e_dir, e_ec, e_es, e_wraps);
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic drive(input logic [N-1:0] code);
    @(negedge clk);
    bus.jin = code;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.jin = 4'b1100;
    repeat (3) @(negedge clk);
    check("rst_phase", int'(bus.phase), 0);
    check("rst_valid", int'(bus.valid), 0);
    check("rst_locked", int'(bus.locked), 0);
    check("rst_wraps", int'(bus.wraps), 0);
    clear = 1'b1;
    @(negedge clk);
    check("pre_sample_valid", int'(bus.valid), 0);
    @(negedge clk);
    check("first_phase", int'(bus.phase), 2);
    check("first_valid", int'(bus.valid), 1);

    drive(4'b0000); drive(4'b1000); drive(4'b1100);
    @(negedge clk);
    check("lock_not_yet", int'(bus.locked), 0);
    @(negedge clk);
    check("lock_rise", int'(bus.locked), 1);
    check("lock_phase", int'(bus.phase), 2);
    drive(4'b1110); drive(4'b1111); drive(4'b0111); drive(4'b0011);
    drive(4'b0001); drive(4'b0000);
    @(negedge clk);
    check("wrap_before", int'(bus.wraps), 0);
    @(negedge clk);
    check("wrap_after", int'(bus.wraps), 1);
    check("wrap_phase", int'(bus.phase), 0);

    drive(4'b1000); drive(4'b1100); drive(4'b1110);
    repeat (10) @(negedge clk);
    check("hold_locked", int'(bus.locked), 1);
    check("hold_phase", int'(bus.phase), 3);
    check("hold_wraps", int'(bus.wraps), 1);

    drive(4'b1010);
    @(negedge clk);
    check("ill_code_pre", int'(bus.locked), 1);
    @(negedge clk);
    check("ill_code_flag", int'(bus.err_code), 1);
    check("ill_code_unlock", int'(bus.locked), 0);
    check("ill_code_phase", int'(bus.phase), 3);
    drive(4'b1111); drive(4'b0111); drive(4'b0011);
    @(negedge clk);
    check("relock_not_yet", int'(bus.locked), 0);
    @(negedge clk);
    check("relock", int'(bus.locked), 1);
    check("err_code_sticky", int'(bus.err_code), 1);

    drive(4'b0001); drive(4'b0000); drive(4'b1000); drive(4'b1100);
    @(negedge clk); @(negedge clk);
    check("at_1100_wraps", int'(bus.wraps), 2);
    drive(4'b1111);
    @(negedge clk);
    check("ill_step_pre", int'(bus.err_step), 0);
    @(negedge clk);
    check("ill_step_flag", int'(bus.err_step), 1);
    check("ill_step_unlock", int'(bus.locked), 0);
    check("ill_step_phase", int'(bus.phase), 4);
    repeat (5) @(negedge clk);
    check("err_step_sticky", int'(bus.err_step), 1);

    @(negedge clk);
    #2 clear = 1'b0;
    #1;
    check("async_phase", int'(bus.phase), 0);
    check("async_err_step", int'(bus.err_step), 0);
    check("async_err_code", int'(bus.err_code), 0);
    check("async_wraps", int'(bus.wraps), 0);
    check("async_valid", int'(bus.valid), 0);
    @(negedge clk);
    bus.jin = 4'b0011;
    clear = 1'b1;
    drive(4'b0001); drive(4'b0000);
    @(negedge clk);
    check("d_hunt_phase", int'(bus.phase), 7);
    @(negedge clk);
    check("d_locked", int'(bus.locked), 1);
    check("d_hunt_wrap_ignored", int'(bus.wraps), 0);

    drive(4'b0001);
    @(negedge clk); @(negedge clk);
    check("d_phase", int'(bus.phase), 7);
`ifdef JDEC_DIR_EN
    check("d_dir", int'(bus.dir), 1);
    check("d_wraps_dec", int'(bus.wraps), 255);
    check("d_stay_locked", int'(bus.locked), 1);
    drive(4'b0000);
    @(negedge clk); @(negedge clk);
    check("d_fwd_dir", int'(bus.dir), 0);
    check("d_wraps_inc", int'(bus.wraps), 0);
`else
    check("d_err_step", int'(bus.err_step), 1);
    check("d_unlock", int'(bus.locked), 0);
    check("d_dir_tied", int'(bus.dir), 0);
`endif
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
